// File: rtl/traffic_phase_controller.sv
// Multi-approach traffic signal controller.
// Cycles ALLRED -> GREEN -> YELLOW -> ALLRED. Approaches without demand are
// skipped, and latched pedestrian requests are served with a walk interval at
// the start of green. Define NIGHT_FLASH_EN to add a night-mode FLASH state in
// which all yellow lamps blink.
module traffic_phase_controller #(
  parameter int CLK_HZ     = 24_000_000,
  parameter int NUM_PHASES = 4,
  parameter int T_GREEN    = 10,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 2,
  parameter int T_WALK     = 7
) (
  input  logic                          sayac,
  input  logic                          reset,
  input  logic [NUM_PHASES-1:0]         arac_talep,
  input  logic [NUM_PHASES-1:0]         yaya_istek,
  input  logic                          gece_modu,
  output logic [NUM_PHASES-1:0]         kirmiziRenk,
  output logic [NUM_PHASES-1:0]         sariRenk,
  output logic [NUM_PHASES-1:0]         yesilRenk,
  output logic [NUM_PHASES-1:0]         yaya_gec,
  output logic [$clog2(NUM_PHASES)-1:0] aktif_faz,
  output logic                          saniye_tick
);
  localparam int PW   = $clog2(NUM_PHASES);
  localparam int CW   = PW + 1;
  localparam int PSW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int TGY  = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int TMAX = (TGY > T_ALLRED) ? TGY : T_ALLRED;
  localparam int SNW  = $clog2(TMAX + 1);

  localparam logic [PSW-1:0] PRESC_LAST  = PSW'(CLK_HZ - 1);
  localparam logic [SNW-1:0] SN_G_LAST   = SNW'(T_GREEN - 1);
  localparam logic [SNW-1:0] SN_Y_LAST   = SNW'(T_YELLOW - 1);
  localparam logic [SNW-1:0] SN_AR_LAST  = SNW'(T_ALLRED - 1);
  localparam logic [SNW-1:0] SN_WALK     = SNW'(T_WALK);
  localparam logic [PW-1:0]  PHASE_LAST  = PW'(NUM_PHASES - 1);
  localparam logic [CW-1:0]  NP          = CW'(NUM_PHASES);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [PSW-1:0]          presc_reg;
  logic [SNW-1:0]          sn_reg, sn_next, t_last;
  logic [PW-1:0]           phase_reg, phase_next, base, sel;
  logic                    first_reg, first_next;
  logic                    walk_en_reg, walk_en_next;
  logic                    flash_reg, flash_next, flash_on;
  logic [NUM_PHASES-1:0]   ped_pend_reg, ped_pend_next, demand;
  logic [NUM_PHASES-1:0]   red_next, yel_next, grn_next, walk_next;
  logic [CW-1:0]           cand;
  logic                    done;

`ifndef NIGHT_FLASH_EN
  // Night mode is not built in; the input is deliberately left unused.
  logic unused_gece;
  assign unused_gece = gece_modu;
`endif

  assign saniye_tick = (presc_reg == PRESC_LAST);

  // Free-running seconds prescaler, never cleared by the FSM.
  always_ff @(posedge sayac or posedge reset) begin
    if (reset)            presc_reg <= '0;
    else if (saniye_tick) presc_reg <= '0;
    else                  presc_reg <= presc_reg + PSW'(1);
  end

  // Next phase: first demanded approach after the current one, else cur+1.
  always_comb begin
    base   = first_reg ? PHASE_LAST : phase_reg;
    demand = arac_talep | ped_pend_reg;
    cand   = {1'b0, base} + CW'(1);
    if (cand >= NP) cand = cand - NP;
    sel = cand[PW-1:0];
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      cand = {1'b0, base} + CW'(k);
      if (cand >= NP) cand = cand - NP;
      if (demand[cand[PW-1:0]]) sel = cand[PW-1:0];
    end
  end

  // Last second index of the current state; a state ends on that tick.
  always_comb begin
    case (state_reg)
      ST_GREEN:  t_last = SN_G_LAST;
      ST_YELLOW: t_last = SN_Y_LAST;
      default:   t_last = SN_AR_LAST;
    endcase
    done = saniye_tick && (sn_reg == t_last);
  end

  // Next-state logic, seconds counter and pedestrian latching.
  always_comb begin
    state_next    = state_reg;
    sn_next       = saniye_tick ? sn_reg + SNW'(1) : sn_reg;
    phase_next    = phase_reg;
    first_next    = first_reg;
    walk_en_next  = walk_en_reg;
    flash_next    = flash_reg;
    ped_pend_next = ped_pend_reg | yaya_istek;
    case (state_reg)
      ST_ALLRED: begin
        if (done) begin
          sn_next = '0;
`ifdef NIGHT_FLASH_EN
          if (gece_modu) begin
            state_next = ST_FLASH;
            flash_next = 1'b1;
          end else
`endif
          begin
            // A request arriving in the entry cycle is served now.
            state_next         = ST_GREEN;
            phase_next         = sel;
            first_next         = 1'b0;
            walk_en_next       = ped_pend_reg[sel] | yaya_istek[sel];
            ped_pend_next[sel] = 1'b0;
          end
        end
      end
      ST_GREEN: begin
        if (done) begin
          state_next = ST_YELLOW;
          sn_next    = '0;
        end
      end
      ST_YELLOW: begin
        if (done) begin
          state_next = ST_ALLRED;
          sn_next    = '0;
        end
      end
      default: begin
`ifdef NIGHT_FLASH_EN
        if (saniye_tick) begin
          if (!gece_modu) begin
            state_next = ST_ALLRED;
            sn_next    = '0;
            first_next = 1'b1;
          end else begin
            flash_next = ~flash_reg;
          end
        end
`else
        state_next = ST_ALLRED;
        sn_next    = '0;
`endif
      end
    endcase
  end

`ifdef NIGHT_FLASH_EN
  assign flash_on = (state_next == ST_FLASH) && flash_next;
`else
  assign flash_on = 1'b0;
`endif

  // Per-approach lamp decode of the upcoming state.
  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_lamp
      assign grn_next[gi]  = (state_next == ST_GREEN) && (phase_next == PW'(gi));
      assign yel_next[gi]  = ((state_next == ST_YELLOW) && (phase_next == PW'(gi))) || flash_on;
      assign red_next[gi]  = !grn_next[gi] && !yel_next[gi] && (state_next != ST_FLASH);
      assign walk_next[gi] = grn_next[gi] && walk_en_next && (sn_next < SN_WALK);
    end
  endgenerate

  // State, counters and registered lamp outputs.
  always_ff @(posedge sayac or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_ALLRED;
      sn_reg       <= '0;
      phase_reg    <= '0;
      first_reg    <= 1'b1;
      walk_en_reg  <= 1'b0;
      flash_reg    <= 1'b0;
      ped_pend_reg <= '0;
      kirmiziRenk  <= '1;
      sariRenk     <= '0;
      yesilRenk    <= '0;
      yaya_gec     <= '0;
    end else begin
      state_reg    <= state_next;
      sn_reg       <= sn_next;
      phase_reg    <= phase_next;
      first_reg    <= first_next;
      walk_en_reg  <= walk_en_next;
      flash_reg    <= flash_next;
      ped_pend_reg <= ped_pend_next;
      kirmiziRenk  <= red_next;
      sariRenk     <= yel_next;
      yesilRenk    <= grn_next;
      yaya_gec     <= walk_next;
    end
  end

  assign aktif_faz = phase_reg;

endmodule
